alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  an operation is presented.
REQ-005 in_ready  output  1  the block accepts the operation this cycle.
REQ-006 alu_cntl  input  4  op code: AND=0, OR=1, XOR=2, LSL=3, RSL=4, RSA=5, ADD=6, SUB=7.
REQ-007 slt_mode  input  2  compare mode: 00 none, 01 signed SLT, 10 unsigned SLTU, 11 illegal.
REQ-008 op_a, op_b  input  XLEN each  operands; shift amount is op_b[4:0].
REQ-009 flush  input  1  discards the in-flight op and any pending result.
REQ-010 out_valid  output  1  result registers hold a valid result.
REQ-011 out_ready  input  1  downstream consumes the result this cycle.
REQ-012 result  output  XLEN  registered result.
REQ-013 zero  output  1  registered flag: result == 0.
REQ-014 illegal  output  1  registered flag: op code or slt_mode not legal.

Function
REQ-015 Accept (fire) occurs when in_valid && in_ready; inputs are sampled only on fire.
REQ-016 in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush.
REQ-017 FSM states: IDLE, SHIFT. IDLE->SHIFT on fire of LSL/RSL/RSA with shamt != 0 in iterative mode; SHIFT->IDLE when the remaining count reaches 0; any state->IDLE on flush.
REQ-018 Single-cycle ops: result, zero and illegal registered on the fire edge; out_valid rises the next cycle (latency 1).
REQ-019 Arithmetic: ADD/SUB modulo 2^32; with slt_mode 01/10 and SUB, result = {31'b0, lt}, where lt is the signed/unsigned compare of op_a < op_b, not the borrow of a truncated difference.
REQ-020 slt_mode != 00 with any code other than SUB, op code > 7, or slt_mode == 11: result = 0, illegal = 1, zero = 1, latency 1.
REQ-021 Shifts: LSL fills with zero; RSL fills with zero; RSA replicates op_a[31]; shamt 0 yields op_a with latency 1.
REQ-022 Iterative shift: shift by 1 bit per cycle; latency = shamt + 1 cycles from fire to out_valid; in_ready is low throughout SHIFT.
REQ-023 out_valid stays high, with result stable, until out_ready is sampled high; it then drops unless a new fire occurs in the same cycle (back-to-back throughput 1/cycle for single-cycle ops).
REQ-024 flush: the next edge clears out_valid, abandons SHIFT and returns to IDLE; flush overrides out_ready and in_valid in the same cycle; no fire occurs while flush is high.
REQ-025 zero and illegal change only when a new result is written.

Reset
REQ-026 While reset_n is low: state = IDLE, out_valid = 0, result = 0, zero = 1, illegal = 0, shift counter = 0; asserting reset mid-SHIFT aborts the op.
REQ-027 On the first edge after reset_n rises, in_ready = 1 if flush is low.

Configuration
REQ-028 Macro ALU_EXEC_FAST_SHIFT_EN: when defined, shifts use a single-cycle barrel shifter and SHIFT is never entered, so every op has latency 1; when undefined, shifts follow REQ-022.

Structure
REQ-029 Shared package alu_pkg: the op code constants (REQ-006), slt_mode encodings, FSM state enum, and XLEN default.
REQ-030 One sub-module, alu_shifter: holds the shift data/count registers, with both iterative and barrel forms selected by ALU_EXEC_FAST_SHIFT_EN; all other logic stays in alu_exec.

Verification
REQ-031 ADD with op_a=0xFFFFFFFF, op_b=1, out_ready=1 -> one cycle later out_valid=1, result=0, zero=1, illegal=0.
REQ-032 SUB with slt_mode=01, op_a=0xFFFFFFFF, op_b=1 -> result=1; same operands with slt_mode=10 -> result=0.
REQ-033 RSA, op_a=0x80000000, op_b=31, iterative build -> in_ready low for 31 cycles, out_valid 32 cycles after fire, result=0xFFFFFFFF; fast build -> latency 1, same result.
REQ-034 Three back-to-back XORs with out_ready held low after the first result -> first result held stable, in_ready=0 until out_ready=1, no result lost or duplicated.
REQ-035 LSL, op_b=10, flush asserted 4 cycles after fire -> out_valid never rises, state returns to IDLE, and a following ADD 2+3 yields 5.
REQ-036 alu_cntl=9 -> result=0, illegal=1; reset_n pulsed low mid-SHIFT -> all outputs at REQ-026 values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes, compare-mode encodings and FSM states for the alu_exec block.
package alu_pkg;

    localparam int XLEN_DEF = 32;
    localparam int SHAMT_W  = 5;

    typedef enum logic [3:0] {
        OP_AND = 4'd0,
        OP_OR  = 4'd1,
        OP_XOR = 4'd2,
        OP_LSL = 4'd3,
        OP_RSL = 4'd4,
        OP_RSA = 4'd5,
        OP_ADD = 4'd6,
        OP_SUB = 4'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        SLT_NONE     = 2'b00,
        SLT_SIGNED   = 2'b01,
        SLT_UNSIGNED = 2'b10,
        SLT_ILLEGAL  = 2'b11
    } slt_mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_LSL) || (op == OP_RSL) || (op == OP_RSA);
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Shift unit for alu_exec: one bit per cycle by default, single-cycle barrel
// shifter when ALU_EXEC_FAST_SHIFT_EN is defined.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               abort,
    input  logic [3:0]         op,
    input  logic [XLEN-1:0]    a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               multi,
    output logic               last,
    output logic [XLEN-1:0]    comb_res,
    output logic [XLEN-1:0]    step_res
);

`ifdef ALU_EXEC_FAST_SHIFT_EN
    logic signed [XLEN-1:0] a_s;
    logic                   unused_ports;

    assign a_s          = a;
    assign unused_ports = ^{clk, reset_n, load, abort};

    always_comb begin
        comb_res = a;
        case (op)
            OP_LSL:  comb_res = a << shamt;
            OP_RSL:  comb_res = a >> shamt;
            OP_RSA:  comb_res = a_s >>> shamt;
            default: comb_res = a;
        endcase
    end

    assign multi    = 1'b0;
    assign last     = 1'b0;
    assign step_res = '0;
`else
    logic [XLEN-1:0]    sh_data_p1;
    logic [3:0]         sh_op_p1;
    logic [SHAMT_W-1:0] sh_cnt;

    function automatic logic [XLEN-1:0] shift1(input logic [3:0] k, input logic [XLEN-1:0] d);
        logic [XLEN-1:0] r;
        case (k)
            OP_LSL:  r = {d[XLEN-2:0], 1'b0};
            OP_RSL:  r = {1'b0, d[XLEN-1:1]};
            default: r = {d[XLEN-1], d[XLEN-1:1]};
        endcase
        return r;
    endfunction

    // Counter is control state and must clear on reset or abort.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         sh_cnt <= '0;
        else if (abort)       sh_cnt <= '0;
        else if (load)        sh_cnt <= shamt;
        else if (sh_cnt != 0) sh_cnt <= sh_cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (load) begin
            sh_data_p1 <= a;
            sh_op_p1   <= op;
        end else if (sh_cnt != 0) begin
            sh_data_p1 <= shift1(sh_op_p1, sh_data_p1);
        end
    end

    assign multi    = (shamt != '0);
    assign last     = (sh_cnt == SHAMT_W'(1));
    assign comb_res = a;
    assign step_res = shift1(sh_op_p1, sh_data_p1);
`endif

endmodule

// File: rtl/alu_exec.sv
// Handshaked ALU execute stage with registered result/zero/illegal outputs.
// Shift implementation selected by ALU_EXEC_FAST_SHIFT_EN (see alu_shifter).
module alu_exec
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_cntl,
    input  logic [1:0]      slt_mode,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    state_e                 state, state_nxt;
    logic                   fire, go_shift, wr_single, wr_shift;
    logic                   legal_p0, shift_p0, lt_s, lt_u;
    logic [XLEN-1:0]        res_p0;
    logic signed [XLEN-1:0] op_a_s, op_b_s;
    logic                   sh_multi, sh_last;
    logic [XLEN-1:0]        sh_comb, sh_step;

    alu_shifter #(.XLEN(XLEN)) u_shifter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (go_shift),
        .abort    (flush),
        .op       (alu_cntl),
        .a        (op_a),
        .shamt    (op_b[SHAMT_W-1:0]),
        .multi    (sh_multi),
        .last     (sh_last),
        .comb_res (sh_comb),
        .step_res (sh_step)
    );

    // Stage p0: decode and single-cycle compute from the presented operands
    assign op_a_s = op_a;
    assign op_b_s = op_b;
    assign lt_s   = op_a_s < op_b_s;
    assign lt_u   = op_a < op_b;

    always_comb begin
        legal_p0 = (alu_cntl <= OP_SUB) && (slt_mode != SLT_ILLEGAL) &&
                   ((slt_mode == SLT_NONE) || (alu_cntl == OP_SUB));
        shift_p0 = legal_p0 && is_shift_op(alu_cntl);
        res_p0   = '0;
        if (legal_p0) begin
            case (alu_cntl)
                OP_AND:  res_p0 = op_a & op_b;
                OP_OR:   res_p0 = op_a | op_b;
                OP_XOR:  res_p0 = op_a ^ op_b;
                OP_ADD:  res_p0 = op_a + op_b;
                OP_SUB: begin
                    if (slt_mode == SLT_SIGNED)        res_p0 = {{(XLEN-1){1'b0}}, lt_s};
                    else if (slt_mode == SLT_UNSIGNED) res_p0 = {{(XLEN-1){1'b0}}, lt_u};
                    else                               res_p0 = op_a - op_b;
                end
                OP_LSL, OP_RSL, OP_RSA: res_p0 = sh_comb;
                default: res_p0 = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (go_shift) state_nxt = ST_SHIFT;
                ST_SHIFT: if (sh_last)  state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == ST_IDLE) && (!out_valid || out_ready) && !flush;
        fire      = in_valid && in_ready;
        go_shift  = fire && shift_p0 && sh_multi;
        wr_single = fire && !go_shift;
        wr_shift  = (state == ST_SHIFT) && sh_last && !flush;
    end

    // Stage p1: registered result; flush beats any pending completion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            illegal   <= 1'b0;
        end else begin
            if (flush)                      out_valid <= 1'b0;
            else if (wr_single || wr_shift) out_valid <= 1'b1;
            else if (out_ready)             out_valid <= 1'b0;

            if (wr_single) begin
                result  <= res_p0;
                zero    <= (res_p0 == '0);
                illegal <= !legal_p0;
            end else if (wr_shift) begin
                result  <= sh_step;
                zero    <= (sh_step == '0);
                illegal <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: reset, op table, shifts, stalls, flush, async reset.
module tb_alu_exec;

    localparam int XLEN = 32;
`ifdef ALU_EXEC_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  op;
        logic [1:0]  slt;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        ill;
    } vec_t;

    localparam vec_t VECS [15] = '{
        '{4'd0, 2'd0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0},
        '{4'd1, 2'd0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0},
        '{4'd2, 2'd0, 32'h12345678, 32'h12345678, 32'h00000000, 1'b0},
        '{4'd6, 2'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0},
        '{4'd7, 2'd0, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0},
        '{4'd7, 2'd1, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0},
        '{4'd7, 2'd2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0},
        '{4'd7, 2'd1, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0},
        '{4'd7, 2'd2, 32'h80000000, 32'h00000001, 32'h00000000, 1'b0},
        '{4'd7, 2'd1, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0},
        '{4'd3, 2'd0, 32'hDEADBEEF, 32'h00000020, 32'hDEADBEEF, 1'b0},
        '{4'd6, 2'd1, 32'h00000003, 32'h00000004, 32'h00000000, 1'b1},
        '{4'd7, 2'd3, 32'h00000009, 32'h00000001, 32'h00000000, 1'b1},
        '{4'd9, 2'd0, 32'h00000009, 32'h00000001, 32'h00000000, 1'b1},
        '{4'd15, 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1}
    };

    logic            clk = 1'b0;
    logic            reset_n;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_cntl;
    logic [1:0]      slt_mode;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    int checks   = 0;
    int failures = 0;

    alu_exec #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_cntl  (alu_cntl),
        .slt_mode  (slt_mode),
        .op_a      (op_a),
        .op_b      (op_b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic drive_op(input logic [3:0] op, input logic [1:0] slt,
                            input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        alu_cntl = op;
        slt_mode = slt;
        op_a     = a;
        op_b     = b;
    endtask

    task automatic settle();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_cntl = '0; slt_mode = '0; op_a = '0; op_b = '0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (result !== 32'h0)   begin failures++; $display("FAIL reset_result got=%h exp=00000000", result); end
        checks++; if (zero !== 1'b1)      begin failures++; $display("FAIL reset_zero got=%b exp=1", zero); end
        checks++; if (illegal !== 1'b0)   begin failures++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_add_wrap();
        settle();
        drive_op(4'd6, 2'd0, 32'hFFFFFFFF, 32'h1);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL add_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1)  begin failures++; $display("FAIL add_out_valid got=%b exp=1", out_valid); end
        checks++; if (result !== 32'h0)    begin failures++; $display("FAIL add_result got=%h exp=00000000", result); end
        checks++; if (zero !== 1'b1)       begin failures++; $display("FAIL add_zero got=%b exp=1", zero); end
        checks++; if (illegal !== 1'b0)    begin failures++; $display("FAIL add_illegal got=%b exp=0", illegal); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0)  begin failures++; $display("FAIL add_consumed got=%b exp=0", out_valid); end
    endtask

    task automatic test_op_table();
        settle();
        for (int i = 0; i < 15; i++) begin
            drive_op(VECS[i].op, VECS[i].slt, VECS[i].a, VECS[i].b);
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || result !== VECS[i].exp) begin
                failures++;
                $display("FAIL op_table[%0d]_result got=%h valid=%b exp=%h", i, result, out_valid, VECS[i].exp);
            end
            checks++;
            if (illegal !== VECS[i].ill) begin
                failures++;
                $display("FAIL op_table[%0d]_illegal got=%b exp=%b", i, illegal, VECS[i].ill);
            end
            checks++;
            if (zero !== (VECS[i].exp == 32'h0)) begin
                failures++;
                $display("FAIL op_table[%0d]_zero got=%b exp=%b", i, zero, (VECS[i].exp == 32'h0));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_shift();
        logic [3:0]  s_op  [4] = '{4'd5, 4'd3, 4'd4, 4'd5};
        logic [31:0] s_a   [4] = '{32'h80000000, 32'h00000001, 32'h80000000, 32'h40000000};
        logic [31:0] s_b   [4] = '{32'd31, 32'd4, 32'd3, 32'd2};
        logic [31:0] s_exp [4] = '{32'hFFFFFFFF, 32'h00000010, 32'h10000000, 32'h10000000};
        int lat, low, exp_lat, exp_low;
        for (int i = 0; i < 4; i++) begin
            settle();
            drive_op(s_op[i], 2'd0, s_a[i], s_b[i]);
            exp_lat = FAST ? 1 : int'(s_b[i]) + 1;
            exp_low = FAST ? 0 : int'(s_b[i]);
            lat = 0;
            low = 0;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                in_valid = 1'b0;
                lat++;
                if (out_valid === 1'b1) break;
                if (in_ready !== 1'b1) low++;
            end
            checks++;
            if (lat !== exp_lat) begin failures++; $display("FAIL shift[%0d]_latency got=%0d exp=%0d", i, lat, exp_lat); end
            checks++;
            if (low !== exp_low) begin failures++; $display("FAIL shift[%0d]_in_ready_low got=%0d exp=%0d", i, low, exp_low); end
            checks++;
            if (result !== s_exp[i]) begin failures++; $display("FAIL shift[%0d]_result got=%h exp=%h", i, result, s_exp[i]); end
        end
    endtask

    task automatic test_back_to_back();
        settle();
        drive_op(4'd2, 2'd0, 32'hA5A5A5A5, 32'h0F0F0F0F);
        out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_first_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        drive_op(4'd2, 2'd0, 32'h12345678, 32'hFFFFFFFF);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b1 || result !== 32'hAAAAAAAA) begin
                failures++;
                $display("FAIL b2b_hold[%0d] got=%h valid=%b exp=aaaaaaaa", k, result, out_valid);
            end
            checks++;
            if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall_ready[%0d] got=%b exp=0", k, in_ready); end
            if (k < 2) @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_release_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || result !== 32'hEDCBA987) begin
            failures++;
            $display("FAIL b2b_second got=%h valid=%b exp=edcba987", result, out_valid);
        end
        drive_op(4'd2, 2'd0, 32'h00000000, 32'h00000001);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 32'h00000001) begin
            failures++;
            $display("FAIL b2b_third got=%h valid=%b exp=00000001", result, out_valid);
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        int seen;
        settle();
        drive_op(4'd3, 2'd0, 32'h00000001, 32'd10);
        out_ready = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== FAST) begin failures++; $display("FAIL flush_pre_valid[%0d] got=%b exp=%b", c, out_valid, FAST); end
        end
        flush = 1'b1;
        drive_op(4'd6, 2'd0, 32'd7, 32'd7);
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_cleared got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL flush_idle_ready got=%b exp=1", in_ready); end
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL flush_stale_valid got=%0d exp=0", seen); end
        drive_op(4'd6, 2'd0, 32'd2, 32'd3);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd5) begin
            failures++;
            $display("FAIL flush_add_after got=%h valid=%b exp=00000005", result, out_valid);
        end
    endtask

    task automatic test_reset_mid_shift();
        int seen;
        settle();
        drive_op(4'd5, 2'd0, 32'h80000000, 32'd20);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_out_valid got=%b exp=0", out_valid); end
        checks++; if (result !== 32'h0)   begin failures++; $display("FAIL arst_result got=%h exp=00000000", result); end
        checks++; if (zero !== 1'b1)      begin failures++; $display("FAIL arst_zero got=%b exp=1", zero); end
        checks++; if (illegal !== 1'b0)   begin failures++; $display("FAIL arst_illegal got=%b exp=0", illegal); end
        checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL arst_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL arst_aborted got=%0d exp=0", seen); end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_op_table();
        test_shift();
        test_back_to_back();
        test_flush();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
